// File: rtl/tone_arb_pkg.sv
// Shared types and codes for the tone arbiter: FSM state encoding and
// the speaker-owner codes driven on out_src.
package tone_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BOX  = 2'd1,
        ST_KEY  = 2'd2,
        ST_GAP  = 2'd3
    } arb_state_t;

    localparam logic [1:0] SRC_SILENT = 2'd0;
    localparam logic [1:0] SRC_KEY    = 2'd1;
    localparam logic [1:0] SRC_BOX    = 2'd2;

    // Owner code presented to the speaker for a given state.
    function automatic logic [1:0] src_of(input arb_state_t st);
        case (st)
            ST_KEY:  return SRC_KEY;
            ST_BOX:  return SRC_BOX;
            default: return SRC_SILENT;
        endcase
    endfunction

endpackage

// File: rtl/arb_timer.sv
// Saturating cycle counter with synchronous clear and count enable, plus a
// terminal-count compare against a caller-supplied limit. Shared between
// the key minimum-hold and the resume gap.
module arb_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         done
);

    // Count up while enabled, stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

    assign done = (count >= limit);

endmodule

// File: rtl/tone_arbiter.sv
// Speaker arbiter between a live piano key and a music box.
// A live key always wins; the music box resumes only after a silent gap
// following the last key release. All outputs are registered from
// next_state, so they lag the inputs by one cycle.
// Optional feature: define TONE_ARB_KEY_HOLD_EN to enforce a minimum of
// HOLD_CYCLES cycles of key ownership even for short key taps.
module tone_arbiter
    import tone_arb_pkg::*;
#(
    parameter int HOLD_CYCLES   = 1_000_000,
    parameter int RESUME_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [31:0] key_freq,
    input  logic        box_en,
    input  logic [31:0] box_freq,
    output logic        box_pause,
    output logic [31:0] out_freq,
    output logic [1:0]  out_src,
    output logic [1:0]  state_dbg
);

    localparam int CNT_MAX = (HOLD_CYCLES > RESUME_CYCLES) ? HOLD_CYCLES : RESUME_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RESUME_LIM = CNT_W'(RESUME_CYCLES - 1);
`ifdef TONE_ARB_KEY_HOLD_EN
    localparam logic [CNT_W-1:0] HOLD_LIM   = CNT_W'(HOLD_CYCLES - 1);
`endif

    arb_state_t       state;
    arb_state_t       next_state;
    logic             key_eff;
    logic             tmr_clear;
    logic             tmr_en;
    logic [CNT_W-1:0] tmr_limit;
    logic [CNT_W-1:0] tmr_count;
    logic             tmr_done;

    // A key with zero frequency is treated as no key at all.
    assign key_eff   = key_valid && (key_freq != 32'd0);
    assign state_dbg = state;

    // The single counter restarts whenever the FSM changes state.
    assign tmr_clear = (next_state != state);
`ifdef TONE_ARB_KEY_HOLD_EN
    assign tmr_en    = (state == ST_KEY) || (state == ST_GAP);
    assign tmr_limit = (state == ST_KEY) ? HOLD_LIM : RESUME_LIM;
`else
    assign tmr_en    = (state == ST_GAP);
    assign tmr_limit = RESUME_LIM;
`endif

    arb_timer #(.W(CNT_W)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (tmr_clear),
        .en    (tmr_en),
        .limit (tmr_limit),
        .count (tmr_count),
        .done  (tmr_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection; a live key takes priority in every state.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (key_eff)     next_state = ST_KEY;
                else if (box_en) next_state = ST_BOX;
            end
            ST_BOX: begin
                if (key_eff)      next_state = ST_KEY;
                else if (!box_en) next_state = ST_IDLE;
            end
            ST_KEY: begin
`ifdef TONE_ARB_KEY_HOLD_EN
                if (!key_eff && tmr_done)
`else
                if (!key_eff)
`endif
                    next_state = box_en ? ST_GAP : ST_IDLE;
            end
            ST_GAP: begin
                if (key_eff)       next_state = ST_KEY;
                else if (!box_en)  next_state = ST_IDLE;
                else if (tmr_done) next_state = ST_BOX;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Registered speaker outputs; during a held-but-released key the last
    // effective key frequency is kept by simply not reloading out_freq.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_freq  <= 32'd0;
            out_src   <= SRC_SILENT;
            box_pause <= 1'b1;
        end else begin
            out_src   <= src_of(next_state);
            box_pause <= (next_state != ST_BOX);
            case (next_state)
                ST_KEY: begin
                    if (key_eff) out_freq <= key_freq;
                end
                ST_BOX:  out_freq <= box_freq;
                default: out_freq <= 32'd0;
            endcase
        end
    end

endmodule

// File: doc/tone_arbiter.md
TONE_ARBITER -- requirements
Module: tone_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 1_000_000: minimum cycles a live key owns the speaker.
REQ-002 Parameter RESUME_CYCLES, default 50_000_000: silent gap after the last key release before the music box resumes.
REQ-003 Port clk  in  1  system clock; the block SHALL use this single clock only.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Port key_valid  in  1  live piano key pressed.
REQ-006 Port key_freq  in  32  live key tone frequency in Hz.
REQ-007 Port box_en  in  1  user enable for music box playback.
REQ-008 Port box_freq  in  32  current music box tone frequency in Hz.
REQ-009 Port box_pause  out  1  pause request to the music box beat controller.
REQ-010 Port out_freq  out  32  selected frequency to the speaker PWM generator.
REQ-011 Port out_src  out  2  owner: 0 silent, 1 key, 2 box; 3 is never driven.

Function
REQ-012 A key SHALL be effective only when key_valid=1 and key_freq!=0; every use of "key" below means an effective key.
REQ-013 The FSM SHALL have states IDLE, BOX, KEY and GAP, with a single cycle counter cleared on every state change.
REQ-014 IDLE SHALL go to KEY on key, else to BOX on box_en, else stay in IDLE.
REQ-015 BOX SHALL go to KEY on key, else to IDLE on !box_en.
REQ-016 KEY SHALL exit only on !key with counter>=HOLD_CYCLES-1, i.e. at least HOLD_CYCLES cycles already spent in KEY.
REQ-017 On that exit, KEY SHALL go to GAP if box_en=1, else to IDLE.
REQ-018 GAP SHALL go to KEY on key, else to IDLE on !box_en, else to BOX once counter reaches RESUME_CYCLES-1.
REQ-019 Key has priority: when key and box_en both assert in the same cycle, the next state SHALL be KEY.
REQ-020 All outputs SHALL be registered and SHALL be a function of next_state and the current inputs, giving one cycle of latency.
REQ-021 For next_state KEY: out_freq=key_freq (tracking key changes every cycle) and out_src=1.
REQ-022 For next_state BOX: out_freq=box_freq and out_src=2.
REQ-023 For next_state IDLE or GAP: out_freq=0 and out_src=0.
REQ-024 While KEY is held below HOLD_CYCLES with the key released, out_freq SHALL hold the last effective key_freq.
REQ-025 box_pause SHALL be 0 only when next_state is BOX, and 1 otherwise.
REQ-026 The counter SHALL be wide enough for max(HOLD_CYCLES, RESUME_CYCLES) and SHALL saturate without wrapping.
REQ-027 box_en falling during KEY SHALL NOT shorten the key; it only selects IDLE on exit.

Reset
REQ-028 Reset SHALL force state=IDLE, counter=0, out_freq=0, out_src=0 and box_pause=1 on the next clk edge.
REQ-029 Reset SHALL take priority over every other input.
REQ-030 Reset asserted mid-note or mid-gap SHALL abort that note or gap with no residual hold or resume.

Configuration
REQ-031 Macro TONE_ARB_KEY_HOLD_EN SHALL control the minimum key hold.
REQ-032 With TONE_ARB_KEY_HOLD_EN defined, minimum hold SHALL behave per REQ-016 and REQ-024.
REQ-033 With TONE_ARB_KEY_HOLD_EN undefined, KEY SHALL exit on the first cycle with !key, HOLD_CYCLES SHALL be ignored, and the counter SHALL be used only by GAP.

Structure
REQ-034 Package tone_arb_pkg SHALL hold the state enum and the out_src codes SRC_SILENT, SRC_KEY and SRC_BOX.
REQ-035 Sub-module arb_timer SHALL be used: a clear/enable saturating counter with a terminal-count compare, shared by KEY and GAP.

Verification (HOLD_CYCLES=4, RESUME_CYCLES=8)
REQ-036 Scenario 1: box_en=1 with box_freq=262 and no key -> one cycle later out_src=2, out_freq=262, box_pause=0.
REQ-037 Scenario 2: during BOX, key 440 is pulsed for 1 cycle -> out_freq=440 for exactly 4 cycles, then 0 for 8 cycles with box_pause=1, then box_freq with box_pause=0.
REQ-038 Scenario 3: in GAP cycle 5, key 494 arrives -> out_freq=494 next cycle; after release, the 8-cycle gap restarts from 0.
REQ-039 Scenario 4: key 330 is held 10 cycles while box_en drops at cycle 3 -> out_freq=330 for 10 cycles, then IDLE, out_freq=0, box_pause=1, and BOX is never re-entered.
REQ-040 Scenario 5: key_valid=1 with key_freq=0 in IDLE with box_en=1 -> BOX is entered; the zero-frequency key is ignored.
REQ-041 Scenario 6: reset asserted at KEY cycle 2 -> next cycle out_freq=0, out_src=0, box_pause=1; with the macro undefined, a 1-cycle key gives exactly 1 cycle of out_freq.
